// File: rtl/mac_seq_if.sv
// Operand stream, MAC hookup and result stream of the MAC sequencer.
interface mac_seq_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [bw-1:0]      in_a;
    logic [bw-1:0]      in_b;
    logic [bw-1:0]      mac_a;
    logic [bw-1:0]      mac_b;
    logic [psum_bw-1:0] mac_c;
    logic [psum_bw-1:0] mac_out;
    logic               out_valid;
    logic               out_ready;
    logic [psum_bw-1:0] out_psum;

    modport slave (
        input  in_valid, in_a, in_b, mac_out, out_ready,
        output in_ready, mac_a, mac_b, mac_c, out_valid, out_psum
    );

    modport master (
        output in_valid, in_a, in_b, mac_out, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, out_valid, out_psum
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: issues one operand pair at a time to a
// latency-MAC_LAT multiply-accumulate and chains the result as next c.
module mac_seq_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int LEN_W   = 4,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    mac_seq_if.slave         bus
);
    localparam int WC_W = $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_inc;
    logic [WC_W-1:0]    wcnt;
    logic [psum_bw-1:0] psum;
    logic [bw-1:0]      a_q;
    logic [bw-1:0]      b_q;
    logic [psum_bw-1:0] c_q;
    logic               fire_in;
    logic               last_tick;

    assign fire_in   = (state == FETCH) && bus.in_valid;
    assign last_tick = (state == WAIT) && (wcnt == WC_W'(1));
    assign cnt_inc   = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (len == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (bus.in_valid) state_nx = WAIT;
            end
            WAIT: begin
                if (last_tick)
                    state_nx = (cnt_inc == len_q) ? DONE : FETCH;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // mac_a/b/c keep the last issued operands until the next issue
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
            cnt   <= '0;
            wcnt  <= '0;
            psum  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q <= len;
                cnt   <= '0;
                psum  <= '0;
            end
            if (fire_in) begin
                a_q  <= bus.in_a;
                b_q  <= bus.in_b;
                c_q  <= psum;
                wcnt <= WC_W'(MAC_LAT);
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (last_tick) begin
                psum <= bus.mac_out;
                cnt  <= cnt_inc;
            end
        end
    end

    assign bus.in_ready  = (state == FETCH);
    assign bus.out_valid = (state == DONE);
    assign bus.out_psum  = psum;
    assign bus.mac_a     = a_q;
    assign bus.mac_b     = b_q;
    assign bus.mac_c     = c_q;
    assign busy          = (state != IDLE);
endmodule
